pc_unit: RTL

Program-counter stage of the multicycle CPU. It sits directly downstream of the multicycle controller and consumes its PCWrite, PCWriteCond and PCSource fields. It holds the architectural PC, evaluates the BNE/BLT/BLE branch condition, and selects the next PC from the ALU result, the ALUOut register or the jump target. It also keeps fetch and taken-branch counters for debug.

---
 rtl/pc_unit.sv | 108 ++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program-counter stage of the multicycle CPU: holds the architectural PC, evaluates
// the BNE/BLT/BLE condition, selects the next PC and keeps debug fetch/taken counters.
module pc_unit #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               JUMP_BITS   = 26,
    parameter int               TAKEN_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   pc_write_i,
    input  logic                   pc_write_cond_i,
    input  logic [1:0]             pc_source_i,
    input  logic [5:0]             opcode_i,
    input  logic [WIDTH-1:0]       reg_a_i,
    input  logic [WIDTH-1:0]       reg_b_i,
    input  logic [WIDTH-1:0]       alu_result_i,
    input  logic [WIDTH-1:0]       alu_out_i,
    input  logic [JUMP_BITS-1:0]   instr_imm_i,
    output logic [WIDTH-1:0]       pc_o,
    output logic [WIDTH-1:0]       pc_next_o,
    output logic                   branch_taken_o,
    output logic [WIDTH-1:0]       fetch_count_o,
    output logic [TAKEN_CNT_W-1:0] taken_count_o
);

    typedef enum logic [1:0] {
        SRC_ALU_RESULT = 2'b00,
        SRC_ALU_OUT    = 2'b01,
        SRC_JUMP       = 2'b10,
        SRC_HOLD       = 2'b11
    } pc_src_e;

    localparam logic [WIDTH-1:0]       FETCH_ONE = WIDTH'(1);
    localparam logic [TAKEN_CNT_W-1:0] TAKEN_ONE = TAKEN_CNT_W'(1);

    logic [WIDTH-1:0]       pc_q, pc_d, pc_next;
    logic                   branch_taken_q, branch_taken_d;
    logic [WIDTH-1:0]       fetch_count_q, fetch_count_d;
    logic [TAKEN_CNT_W-1:0] taken_count_q, taken_count_d;
    pc_src_e                src;
    logic                   cond, load, taken_evt, fetch_evt;

    assign src = pc_src_e'(pc_source_i);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        cond = 1'b0;
        if (opcode_i[5:4] == 2'b10) begin
            case (opcode_i[1:0])
                2'b01:   cond = (reg_a_i != reg_b_i);
                2'b10:   cond = ($signed(reg_a_i) <  $signed(reg_b_i));
                2'b11:   cond = ($signed(reg_a_i) <= $signed(reg_b_i));
                default: cond = 1'b0;
            endcase
        end
    end

    // Jump keeps the upper bits of the already-incremented PC; word-addressed.
    always_comb begin
        pc_next = pc_q;
        case (src)
            SRC_ALU_RESULT: pc_next = alu_result_i;
            SRC_ALU_OUT:    pc_next = alu_out_i;
            SRC_JUMP:       pc_next = {pc_q[WIDTH-1:JUMP_BITS], instr_imm_i};
            default:        pc_next = pc_q;
        endcase
    end

    assign load      = pc_write_i | (pc_write_cond_i & cond);
    assign taken_evt = pc_write_cond_i & cond & ~pc_write_i & (src != SRC_HOLD);
    assign fetch_evt = pc_write_i & (src == SRC_ALU_RESULT);

    always_comb begin
        pc_d           = load ? pc_next : pc_q;
        branch_taken_d = taken_evt;
        fetch_count_d  = fetch_count_q;
        taken_count_d  = taken_count_q;
        if (fetch_evt && (fetch_count_q != '1)) begin
            fetch_count_d = fetch_count_q + FETCH_ONE;
        end
        if (taken_evt && (taken_count_q != '1)) begin
            taken_count_d = taken_count_q + TAKEN_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q           <= RESET_PC;
            branch_taken_q <= 1'b0;
            fetch_count_q  <= '0;
            taken_count_q  <= '0;
        end else begin
            pc_q           <= pc_d;
            branch_taken_q <= branch_taken_d;
            fetch_count_q  <= fetch_count_d;
            taken_count_q  <= taken_count_d;
        end
    end

    assign pc_o           = pc_q;
    assign pc_next_o      = pc_next;
    assign branch_taken_o = branch_taken_q;
    assign fetch_count_o  = fetch_count_q;
    assign taken_count_o  = taken_count_q;

endmodule
